uart_tx_io_port: RTL

Output-port peripheral on the RAT CPU I/O bus, directly downstream of the CPU's `port_id`/`out_port`/`io_strb` outputs and upstream of its `in_port` and `input_interrupt` inputs. Each `OUT` to the data port pushes a byte into a transmit FIFO. An 8N1 UART serializer drains the FIFO. A status byte is readable with `IN`, and a drain interrupt can be raised to the CPU.

---
 rtl/uart_tx_io_port.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_io_port.sv
// RAT CPU I/O-bus UART transmitter: OUT-driven byte FIFO feeding an 8N1 serializer.
// Optional drain interrupt enabled by defining UART_TX_IRQ_EN.
module uart_tx_io_port #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [7:0]  TX_DATA_PORT = 8'h40,
    parameter logic [7:0]  STATUS_PORT  = 8'h41
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       io_strb,
    output logic [7:0] in_port,
    output logic       tx,
    output logic       irq
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             overflow_q;

    state_e           state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic empty, full, baud_end, busy;
    logic push_req, clr_req, push_ok, ovf_set, pop;
    logic irq_cap;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CntFull);
    assign baud_end = (baud_q == BaudLast);
    assign busy     = (state_q != StIdle);
    assign push_req = io_strb && (port_id == TX_DATA_PORT);
    assign clr_req  = io_strb && (port_id == STATUS_PORT);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign count_d  = count_q + {{PtrW{1'b0}}, push_ok} - {{PtrW{1'b0}}, pop};

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so frames stay gapless.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (clr_req) begin
                overflow_q <= 1'b0;
            end else if (ovf_set) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= out_port;
    end

`ifdef UART_TX_IRQ_EN
    logic irq_q;
    logic frame_done;

    assign frame_done = (state_q == StStop) && baud_end && empty;
    assign irq_cap    = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= frame_done;
    end

    assign irq = irq_q;
`else
    assign irq_cap = 1'b0;
    assign irq     = 1'b0;
`endif

    always_comb begin
        in_port = 8'h00;
        if (port_id == STATUS_PORT) begin
            in_port = {3'b000, irq_cap, overflow_q, busy, empty, full};
        end
    end

    assign tx = tx_q;

endmodule
